// File: rtl/adc_conv_sched_pkg.sv
// Shared definitions for the ADC conversion scheduler: widths, state encoding and
// the offset-correction helper.
package adc_conv_sched_pkg;

  localparam int unsigned ADC_W        = 10;
  localparam int unsigned OFS_W        = 11;
  localparam int unsigned MIDSCALE_DEF = 512;
  localparam int unsigned N_REQ        = 2;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StCalStart  = 3'd1;
  localparam logic [2:0] StCalWait   = 3'd2;
  localparam logic [2:0] StArb       = 3'd3;
  localparam logic [2:0] StConvStart = 3'd4;
  localparam logic [2:0] StConvWait  = 3'd5;
  localparam logic [2:0] StResp      = 3'd6;

  // raw - ofs evaluated in 13 bits so neither end can wrap, then clamped to the code range.
  function automatic logic [ADC_W-1:0] correct_code(input logic [ADC_W-1:0] raw,
                                                    input logic [OFS_W-1:0] ofs);
    logic [OFS_W+1:0] diff;
    diff = {3'b000, raw} - {{2{ofs[OFS_W-1]}}, ofs};
    if (diff[OFS_W+1]) begin
      return '0;
    end else if (diff[OFS_W:ADC_W] != '0) begin
      return '1;
    end else begin
      return diff[ADC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/adc_conv_sched_if.sv
// Requester and ADC-side signals of the conversion scheduler; master is the scheduler.
interface adc_conv_sched_if;
  import adc_conv_sched_pkg::*;

  logic [N_REQ-1:0] req;
  logic             cal_req;
  logic             adc_done;
  logic [ADC_W-1:0] adc_result;
  logic             st_conv;
  logic             cal;
  logic [N_REQ-1:0] ack;
  logic [ADC_W-1:0] data;
  logic             err;
  logic [OFS_W-1:0] cal_offset;
  logic             cal_valid;
  logic             busy;

  modport master (
    input  req, cal_req, adc_done, adc_result,
    output st_conv, cal, ack, data, err, cal_offset, cal_valid, busy
  );

  modport slave (
    output req, cal_req, adc_done, adc_result,
    input  st_conv, cal, ack, data, err, cal_offset, cal_valid, busy
  );

endinterface

// File: rtl/adc_done_sync.sv
// Two-flop synchronizer for the ADC done flag plus rising-edge detector.
module adc_done_sync (
  input  logic clk,
  input  logic rst,
  input  logic adc_done,
  output logic done_evt
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], adc_done};
    end
  end

  // sync_q[2] only remembers the previous synchronized level for edge detection.
  assign done_evt = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_conv_sched.sv
// Schedules conversions for two requesters on one ADC, with periodic and on-demand
// offset calibration and a per-conversion timeout.
module adc_conv_sched
  import adc_conv_sched_pkg::*;
#(
  parameter int unsigned CAL_PERIOD = 64,
  parameter int unsigned TIMEOUT    = 63,
  parameter int unsigned MIDSCALE   = MIDSCALE_DEF
) (
  input logic             clk,
  input logic             rst,
  adc_conv_sched_if.master bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = $clog2(CAL_PERIOD + 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CAL_PERIOD);
  localparam logic [OFS_W-1:0] MID_CODE = OFS_W'(MIDSCALE);

  logic [2:0]       state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;
  logic             cal_pend_q, cal_pend_d;
  logic             boot_q, boot_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [OFS_W-1:0] ofs_q, ofs_d;
  logic             cal_valid_q, cal_valid_d;
  logic             done_evt;
  logic             timeout;
  logic             gnt;

  adc_done_sync u_done_sync (
    .clk      (clk),
    .rst      (rst),
    .adc_done (bus.adc_done),
    .done_evt (done_evt)
  );

  assign timeout = (to_cnt_q == TO_MAX);

  // With both requesting, alternate away from the last grant; otherwise serve whoever asks.
  always_comb begin
    gnt = 1'b0;
    if (&bus.req) begin
      gnt = ~last_q;
    end else if (bus.req[1]) begin
      gnt = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    conv_cnt_d  = conv_cnt_q;
    boot_d      = boot_q;
    last_d      = last_q;
    grant_d     = grant_q;
    data_d      = data_q;
    err_d       = err_q;
    ofs_d       = ofs_q;
    cal_valid_d = cal_valid_q;

    unique case (state_q)
      StIdle: begin
        if (boot_q || cal_pend_q || (conv_cnt_q == CNT_MAX)) begin
          state_d = StCalStart;
          boot_d  = 1'b0;
        end else if (|bus.req) begin
          state_d = StArb;
        end
      end
      StCalStart: begin
        to_cnt_d = '0;
        state_d  = StCalWait;
      end
      StCalWait: begin
        if (done_evt) begin
          ofs_d       = {1'b0, bus.adc_result} - MID_CODE;
          cal_valid_d = 1'b1;
          conv_cnt_d  = '0;
          state_d     = StIdle;
        end else if (timeout) begin
          ofs_d       = '0;
          cal_valid_d = 1'b0;
          state_d     = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StArb: begin
        if (|bus.req) begin
          grant_d = gnt;
          last_d  = gnt;
          state_d = StConvStart;
        end else begin
          state_d = StIdle;
        end
      end
      StConvStart: begin
        to_cnt_d = '0;
        state_d  = StConvWait;
      end
      StConvWait: begin
        if (done_evt) begin
          data_d  = correct_code(bus.adc_result, ofs_q);
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (conv_cnt_q != CNT_MAX) begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Entering CAL_START satisfies any outstanding request, including one arriving that cycle.
  always_comb begin
    cal_pend_d = cal_pend_q | bus.cal_req;
    if ((state_q == StIdle) && (state_d == StCalStart)) begin
      cal_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      to_cnt_q    <= '0;
      conv_cnt_q  <= '0;
      cal_pend_q  <= 1'b0;
      boot_q      <= 1'b1;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      ofs_q       <= '0;
      cal_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      conv_cnt_q  <= conv_cnt_d;
      cal_pend_q  <= cal_pend_d;
      boot_q      <= boot_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      err_q       <= err_d;
      ofs_q       <= ofs_d;
      cal_valid_q <= cal_valid_d;
    end
  end

  assign bus.st_conv    = (state_q == StCalStart) || (state_q == StConvStart);
  assign bus.cal        = (state_q == StCalStart) || (state_q == StCalWait);
  assign bus.ack        = (state_q == StResp) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.data       = data_q;
  assign bus.err        = err_q;
  assign bus.cal_offset = ofs_q;
  assign bus.cal_valid  = cal_valid_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_adc_conv_sched.sv
// Directed bench for adc_conv_sched with a behavioural ADC that answers st_conv after a
// fixed delay, returning a calibration or conversion code chosen by the stimulus.
module tb_adc_conv_sched;
  import adc_conv_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;

  adc_conv_sched_if bus ();

  adc_conv_sched #(
    .CAL_PERIOD (4),
    .TIMEOUT    (63),
    .MIDSCALE   (512)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] cal_code;
  logic [9:0] conv_code;
  logic [9:0] adc_code;
  logic       adc_mute;

  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       recal_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [1:0] a;
  int         cyc, hi, st;
  logic       ok;
  logic       any_ack;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ADC model: sees st_conv on the falling edge, raises done 3 rising edges later for 2 cycles.
  initial begin
    bus.adc_done   = 1'b0;
    bus.adc_result = '0;
    forever begin
      @(negedge clk);
      if (bus.st_conv && !adc_mute) begin
        adc_code = bus.cal ? cal_code : conv_code;
        repeat (3) @(posedge clk);
        #1;
        bus.adc_result = adc_code;
        bus.adc_done   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.adc_done = 1'b0;
      end
    end
  end

  task automatic wait_ack(input int limit, output logic [1:0] ack_v, output int lat);
    ack_v = '0;
    lat   = limit;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        ack_v = bus.ack;
        lat   = i;
        return;
      end
    end
  endtask

  task automatic wait_cal(input int limit, output int hi_cyc, output int st_cnt, output logic done);
    int i;
    i      = 0;
    hi_cyc = 0;
    st_cnt = 0;
    while (!bus.cal && i < limit) begin
      @(negedge clk);
      i++;
    end
    while (bus.cal && i < limit) begin
      hi_cyc++;
      if (bus.st_conv) st_cnt++;
      @(negedge clk);
      i++;
    end
    done = !bus.cal && (hi_cyc > 0);
  endtask

  task automatic do_conv(input string tag, input logic [1:0] r, input logic [9:0] raw,
                         input logic [1:0] exp_ack, input logic [9:0] exp_data,
                         input logic exp_err, output int lat);
    logic [1:0] ack_v;
    conv_code = raw;
    bus.req   = r;
    wait_ack(200, ack_v, lat);
    check_eq({tag, "_ack"}, 32'(ack_v), 32'(exp_ack));
    check_eq({tag, "_data"}, 32'(bus.data), 32'(exp_data));
    check_eq({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    bus.req = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_st_conv"}, 32'(bus.st_conv), 0);
    check_eq({tag, "_cal"}, 32'(bus.cal), 0);
    check_eq({tag, "_ack"}, 32'(bus.ack), 0);
    check_eq({tag, "_data"}, 32'(bus.data), 0);
    check_eq({tag, "_err"}, 32'(bus.err), 0);
    check_eq({tag, "_cal_offset"}, 32'(bus.cal_offset), 0);
    check_eq({tag, "_cal_valid"}, 32'(bus.cal_valid), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.req     = '0;
    bus.cal_req = 1'b0;
    cal_code    = 10'd515;
    conv_code   = '0;
    adc_mute    = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Boot calibration: 515 against midscale 512.
    rst = 1'b0;
    @(negedge clk);
    check_eq("boot_cal", 32'(bus.cal), 1);
    check_eq("boot_st_conv", 32'(bus.st_conv), 1);
    check_eq("boot_busy", 32'(bus.busy), 1);
    wait_cal(100, hi, st, ok);
    check_eq("boot_cal_done", 32'(ok), 1);
    check_eq("boot_cal_len", 32'(hi), 6);
    check_eq("boot_cal_st_pulses", 32'(st), 1);
    check_eq("boot_cal_offset", 32'(bus.cal_offset), 3);
    check_eq("boot_cal_valid", 32'(bus.cal_valid), 1);
    check_eq("boot_idle", 32'(bus.busy), 0);

    // Round robin with both requests held; offset +3, raw 200.
    cal_code  = 10'd509;
    conv_code = 10'd200;
    bus.req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(200, a, cyc);
      check_eq("rr_ack", 32'(a), 32'(rr_exp[k]));
      check_eq("rr_data", 32'(bus.data), 197);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_eq("period_recal", 32'(bus.cal), 1);
    wait_cal(100, hi, st, ok);
    check_eq("neg_cal_done", 32'(ok), 1);
    check_eq("neg_cal_offset", 32'(bus.cal_offset), 32'h7FD);
    check_eq("neg_cal_valid", 32'(bus.cal_valid), 1);

    // Offset -3: 1022 + 3 saturates.
    do_conv("clamp_hi", 2'b01, 10'd1022, 2'b01, 10'd1023, 1'b0, cyc);

    // cal_req pulse while the conversion is waiting on the ADC.
    cal_code  = 10'd515;
    conv_code = 10'd500;
    bus.req   = 2'b01;
    repeat (5) @(negedge clk);
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    wait_ack(200, a, cyc);
    check_eq("calreq_conv_ack", 32'(a), 1);
    check_eq("calreq_conv_data", 32'(bus.data), 503);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_eq("calreq_recal", 32'(bus.cal), 1);
    wait_cal(100, hi, st, ok);
    check_eq("calreq_cal_done", 32'(ok), 1);
    check_eq("calreq_cal_offset", 32'(bus.cal_offset), 3);

    // Offset +3: nominal conversion with latency, then clamp low.
    do_conv("nominal", 2'b01, 10'd100, 2'b01, 10'd97, 1'b0, cyc);
    check_eq("nominal_latency", 32'(cyc), 8);
    do_conv("clamp_lo", 2'b01, 10'd1, 2'b01, 10'd0, 1'b0, cyc);

    // req[0] held across 6 acks; counter is at 2, so recal follows acks 2 and 6.
    conv_code = 10'd100;
    bus.req   = 2'b01;
    for (int k = 0; k < 6; k++) begin
      wait_ack(200, a, cyc);
      check_eq("held_ack", 32'(a), 1);
      check_eq("held_data", 32'(bus.data), 97);
      repeat (2) @(negedge clk);
      check_eq("held_recal", 32'(bus.cal), 32'(recal_exp[k]));
    end
    bus.req = '0;
    wait_cal(100, hi, st, ok);
    check_eq("held_cal_done", 32'(ok), 1);

    // ADC silent during a conversion.
    adc_mute = 1'b1;
    do_conv("conv_timeout", 2'b01, 10'd100, 2'b01, 10'd0, 1'b1, cyc);
    check_eq("conv_timeout_latency", 32'(cyc), 67);
    adc_mute = 1'b0;
    do_conv("after_timeout", 2'b01, 10'd100, 2'b01, 10'd97, 1'b0, cyc);

    // Reset in the middle of a conversion.
    conv_code = 10'd100;
    bus.req   = 2'b01;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", 32'(bus.busy), 1);
    rst     = 1'b1;
    any_ack = 1'b0;
    @(negedge clk);
    bus.req = '0;
    check_reset_outputs("mid_rst");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      any_ack = any_ack | (|bus.ack);
    end
    check_eq("mid_rst_no_ack", 32'(any_ack), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cal", 32'(bus.cal), 1);
    wait_cal(100, hi, st, ok);
    check_eq("post_rst_cal_done", 32'(ok), 1);
    check_eq("post_rst_cal_offset", 32'(bus.cal_offset), 3);
    check_eq("post_rst_cal_valid", 32'(bus.cal_valid), 1);

    // Calibration that times out drops the stored offset.
    adc_mute    = 1'b1;
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    wait_cal(200, hi, st, ok);
    check_eq("cal_timeout_done", 32'(ok), 1);
    check_eq("cal_timeout_len", 32'(hi), 65);
    check_eq("cal_timeout_valid", 32'(bus.cal_valid), 0);
    check_eq("cal_timeout_offset", 32'(bus.cal_offset), 0);
    adc_mute = 1'b0;
    do_conv("zero_offset", 2'b01, 10'd100, 2'b01, 10'd100, 1'b0, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_conv_sched.md
ADC_CONV_SCHED -- requirements
Module: adc_conv_sched

Interface
REQ-001 Parameter CAL_PERIOD, default 64, number of normal conversions between automatic recalibrations.
REQ-002 Parameter TIMEOUT, default 63, maximum clk cycles to wait for adc_done after st_conv.
REQ-003 Parameter MIDSCALE, default 512, expected calibration code.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  2  per-requester conversion request, level, held until matching ack.
REQ-007 cal_req  input  1  one-cycle pulse forcing recalibration before the next normal conversion.
REQ-008 adc_done  input  1  ADC FSM done flag, asynchronous to clk.
REQ-009 adc_result  input  10  ADC raw code, stable while adc_done high.
REQ-010 st_conv  output  1  one-cycle start pulse to ADC FSM.
REQ-011 cal  output  1  ADC calibration-mode level.
REQ-012 ack  output  2  one-hot one-cycle grant-complete pulse; data/err valid same cycle.
REQ-013 data  output  10  offset-corrected result.
REQ-014 err  output  1  timeout flag, valid with ack.
REQ-015 cal_offset  output  11  signed stored offset (two's complement).
REQ-016 cal_valid  output  1  high once a calibration completed without timeout.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 adc_done SHALL pass a 2-flop synchronizer; completion is the rising edge of the synchronized signal (done_evt).
REQ-019 States SHALL be IDLE, CAL_START, CAL_WAIT, ARB, CONV_START, CONV_WAIT, RESP.
REQ-020 After reset release the FSM SHALL go IDLE->CAL_START in the first cycle, unconditionally.
REQ-021 CAL_START: cal=1, st_conv=1 for one cycle, timeout counter cleared, -> CAL_WAIT; cal stays 1 through CAL_WAIT.
REQ-022 CAL_WAIT on done_evt: cal_offset = adc_result - MIDSCALE (11-bit signed), cal_valid=1, cal=0, conversion counter cleared, -> IDLE.
REQ-023 CAL_WAIT timeout (counter reaches TIMEOUT): cal_offset=0, cal_valid=0, cal=0, -> IDLE.
REQ-024 IDLE: pending recal (counter == CAL_PERIOD or latched cal_req) -> CAL_START; else any req -> ARB; else stay.
REQ-025 cal_req arriving in any state SHALL be latched and cleared when CAL_START is entered.
REQ-026 ARB: round-robin; with both req high, grant the requester not granted last; after reset requester 0 has priority; -> CONV_START.
REQ-027 CONV_START: st_conv=1 one cycle, cal=0, -> CONV_WAIT.
REQ-028 CONV_WAIT on done_evt: data = clamp(adc_result - cal_offset, 0, 1023), err=0, -> RESP.
REQ-029 CONV_WAIT timeout: data=0, err=1, -> RESP.
REQ-030 RESP: ack[grant]=1 for exactly one cycle, conversion counter += 1 (saturating at CAL_PERIOD), -> IDLE.
REQ-031 A requester deasserting req mid-conversion SHALL still receive its ack; no abort.
REQ-032 Minimum latency req->ack SHALL be 5 cycles plus ADC time plus 2 synchronizer cycles.
REQ-033 st_conv SHALL never assert while busy with an outstanding conversion; at most one conversion in flight.

Reset
REQ-034 On rst: state=IDLE, st_conv=0, cal=0, ack=0, data=0, err=0, cal_offset=0, cal_valid=0, synchronizer=0, counters=0, round-robin pointer=requester 1 last, cal_req latch=0.
REQ-035 rst asserted mid-conversion SHALL abort immediately with all outputs at reset values; no ack issued.

Structure
REQ-036 Shared package SHALL hold the state encoding, ADC width (10), MIDSCALE default and offset width (11).
REQ-037 The done synchronizer/edge detector SHALL be one sub-module, adc_done_sync.

Verification
REQ-038 Reset release, ADC returns 515 on cal -> cal_offset=+3, cal_valid=1, cal high only CAL_START..done.
REQ-039 Offset +3, req[0] with raw 100 -> ack=01, data=97, err=0; raw 1 -> data=0 (clamp low); offset -3, raw 1022 -> data=1023 (clamp high).
REQ-040 req=11 held for 4 conversions -> ack sequence 01,10,01,10.
REQ-041 ADC never raises adc_done -> ack after TIMEOUT cycles with err=1, data=0; cal timeout -> cal_valid=0, cal_offset=0.
REQ-042 CAL_PERIOD=4, req[0] held -> calibration inserted after every 4th ack; cal_req pulse during CONV_WAIT -> cal runs before next conversion.
REQ-043 rst pulse during CONV_WAIT -> no ack, all outputs reset, new calibration follows release.
